// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven HH:MM:SS edit session with shadow registers, load strobe, blink and idle timeout.
// Define CLOCK_SET_AUTOREPEAT_EN to add hold-to-repeat stepping on inc/dec.
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT_S     = 30,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load,
    output logic [1:0] mode,
    output logic       blink
);
    typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;
    localparam int IW = $clog2(TIMEOUT_S + 1);
    if (TIMEOUT_S == 0 || REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_param_check
        $error("clock_set_ctrl: invalid TIMEOUT_S/REPEAT_* parameters");
    end
    state_t        mode_q, mode_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d, sec_q, sec_d;
    logic          load_q, load_d, blink_q, blink_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [2:0]    prev_q;
    logic          mode_p, inc_p, dec_p, rep_up, rep_dn, up, dn, act, timeout;
    assign mode_p  = btn_mode & ~prev_q[2];
    assign inc_p   = btn_inc & ~prev_q[1];
    assign dec_p   = btn_dec & ~prev_q[0];
    assign up      = (inc_p | rep_up) & ~(dec_p | rep_dn);
    assign dn      = (dec_p | rep_dn) & ~(inc_p | rep_up);
    assign act     = mode_p | inc_p | dec_p | rep_up | rep_dn;
    assign timeout = (mode_q != RUN) & ~act & tick_1hz & (idle_q == IW'(TIMEOUT_S - 1));
`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    logic [RW-1:0] rep_q, rep_d;
    logic          rep_fire;
    // rep_q counts prior held cycles; after a step it reloads so the next step lands REPEAT_PERIOD later
    always_comb begin
        rep_fire = (rep_q == RW'(REPEAT_DELAY));
        rep_d    = (mode_q == RUN || mode_p || timeout || !(btn_inc | btn_dec)) ? '0 :
                   rep_fire ? RW'(REPEAT_DELAY - REPEAT_PERIOD + 1) : rep_q + 1'b1;
    end
    assign rep_up = rep_fire & btn_inc;
    assign rep_dn = rep_fire & btn_dec;
    always_ff @(posedge clk) begin
        if (reset) rep_q <= '0;
        else       rep_q <= rep_d;
    end
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif
    always_comb begin
        mode_d  = mode_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        load_d  = 1'b0;
        blink_d = blink_q;
        idle_d  = idle_q;
        if (mode_q == RUN) begin
            hour_d  = cur_hour;
            min_d   = cur_min;
            sec_d   = cur_sec;
            idle_d  = '0;
            blink_d = mode_p;
            mode_d  = mode_p ? SET_HOUR : RUN;
        end else if (mode_p) begin
            mode_d  = state_t'(mode_q + 2'd1);
            load_d  = (mode_q == SET_SEC);
            blink_d = (mode_q != SET_SEC);
            idle_d  = '0;
        end else if (timeout) begin
            mode_d  = RUN;
            blink_d = 1'b0;
            idle_d  = '0;
        end else begin
            idle_d  = act ? '0 : idle_q + IW'(tick_1hz);
            blink_d = blink_q ^ tick_1hz;
            hour_d  = (mode_q != SET_HOUR) ? hour_q :
                      up ? ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1) :
                      dn ? ((hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1) : hour_q;
            min_d   = (mode_q != SET_MIN) ? min_q :
                      up ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1) :
                      dn ? ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1) : min_q;
            sec_d   = (mode_q != SET_SEC) ? sec_q :
                      up ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1) :
                      dn ? ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1) : sec_q;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= RUN;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            load_q  <= 1'b0;
            blink_q <= 1'b0;
            idle_q  <= '0;
            prev_q  <= 3'b111;
        end else begin
            mode_q  <= mode_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            load_q  <= load_d;
            blink_q <= blink_d;
            idle_q  <= idle_d;
            prev_q  <= {btn_mode, btn_inc, btn_dec};
        end
    end
    assign set_hour = hour_q;
    assign set_min  = min_q;
    assign set_sec  = sec_q;
    assign load     = load_q;
    assign mode     = mode_q;
    assign blink    = blink_q;
endmodule
